// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// State encoding is fixed so debug tooling can decode it.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_using_nand.sv
// One-bit full adder built purely from 2-input NAND gates.
// Nine gates: four form the XOR, the rest fold in carry.
module fa_using_nand (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic n1, n2, n3, x1, n4, n5, n6;

  assign n1    = ~(a & b);
  assign n2    = ~(a & n1);
  assign n3    = ~(b & n1);
  assign x1    = ~(n2 & n3);
  assign n4    = ~(x1 & c);
  assign n5    = ~(x1 & n4);
  assign n6    = ~(c & n4);
  assign sum   = ~(n5 & n6);
  assign carry = ~(n1 & n4);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: LSB-first, one full-adder step per RUN cycle.
// Result and carry are registered when the last bit is processed.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  fa_using_nand u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .c    (carry_q),
    .sum  (fa_s),
    .carry(fa_c)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        // Last bit: publish the fully shifted result this edge.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = {fa_s, acc_q[WIDTH-1:1]};
          cout_d  = fa_c;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of the serial adder against a+b+cin.
// An 8-bit and a 4-bit instance share clock and reset.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] prev_sum;
  logic       prev_cout;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start4),
    .a    (a4),
    .b    (b4),
    .cin  (cin4),
    .busy (busy4),
    .done (done4),
    .sum  (sum4),
    .cout (cout4)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit add; timing and result come from plain arithmetic.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic c, input bit hold, input bit scram);
    logic [8:0] exp;
    exp    = {1'b0, a} + {1'b0, b} + 9'(c);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    cin8   = c;
    tick();
    if (!hold) start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("busy_run", 64'(busy8), 64'(1));
      check("done_run", 64'(done8), 64'(0));
      check("sum_stable", 64'(sum8), 64'(prev_sum));
      check("cout_stable", 64'(cout8), 64'(prev_cout));
      if (scram) begin
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        cin8 = 1'($urandom);
      end
      tick();
    end
    check("done_pulse", 64'(done8), 64'(1));
    check("busy_done", 64'(busy8), 64'(0));
    check("sum", 64'(sum8), 64'(exp[7:0]));
    check("cout", 64'(cout8), 64'(exp[8]));
    prev_sum  = exp[7:0];
    prev_cout = exp[8];
    tick();
    check("done_after", 64'(done8), 64'(0));
    check("busy_idle", 64'(busy8), 64'(0));
    check("sum_after", 64'(sum8), 64'(prev_sum));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     input logic c);
    logic [4:0] exp;
    exp    = {1'b0, a} + {1'b0, b} + 5'(c);
    start4 = 1'b1;
    a4     = a;
    b4     = b;
    cin4   = c;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("w4_done_run", 64'(done4), 64'(0));
      tick();
    end
    check("w4_done", 64'(done4), 64'(1));
    check("w4_res", 64'({cout4, sum4}), 64'(exp));
    tick();
    check("w4_done_after", 64'(done4), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    start8    = 1'b0;
    start4    = 1'b0;
    a8        = 8'h00;
    b8        = 8'h00;
    cin8      = 1'b0;
    a4        = 4'h0;
    b4        = 4'h0;
    cin4      = 1'b0;
    prev_sum  = 8'h00;
    prev_cout = 1'b0;
    #12;
    check("rst_busy", 64'(busy8), 64'(0));
    check("rst_done", 64'(done8), 64'(0));
    check("rst_sum", 64'(sum8), 64'(0));
    check("rst_cout", 64'(cout8), 64'(0));
    rst_n = 1'b1;
    tick();

    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    op8(8'h21, 8'h43, 1'b1, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

    op8(8'h5A, 8'h3C, 1'b0, 1'b1, 1'b1);
    op8(8'hC3, 8'h7E, 1'b1, 1'b1, 1'b1);
    op8(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom));

    start8 = 1'b1;
    a8     = 8'h77;
    b8     = 8'h11;
    cin8   = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy8), 64'(0));
    check("arst_done", 64'(done8), 64'(0));
    check("arst_sum", 64'(sum8), 64'(0));
    check("arst_cout", 64'(cout8), 64'(0));
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("arst_no_done", 64'(done8), 64'(0));
      check("arst_no_busy", 64'(busy8), 64'(0));
    end
    prev_sum  = 8'h00;
    prev_cout = 1'b0;
    op8(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 512; i++)
      op4(4'(i >> 5), 4'(i >> 1), 1'(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
